// File: rtl/system_0_sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words and
// compares them against build-time expected values.
module system_0_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1687962903,
    parameter logic [15:0] TIMEOUT_CYCLES     = 16'd255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic [31:0] id_value,
    output logic [31:0] timestamp_value,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, FIN} state_t;

    state_t      state, state_next;
    logic        auto_start, auto_start_next;
    logic [15:0] stall_cnt, stall_cnt_next;
    logic [31:0] id_value_next, timestamp_value_next;
    logic        id_ok_next, ts_ok_next, timeout_err_next;
    logic        done_next, busy_next, read_next, address_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            auto_start      <= 1'b1;
            stall_cnt       <= '0;
            id_value        <= '0;
            timestamp_value <= '0;
            id_ok           <= 1'b0;
            ts_ok           <= 1'b0;
            timeout_err     <= 1'b0;
            done            <= 1'b0;
            busy            <= 1'b0;
            avm_read        <= 1'b0;
            avm_address     <= 1'b0;
        end else begin
            state           <= state_next;
            auto_start      <= auto_start_next;
            stall_cnt       <= stall_cnt_next;
            id_value        <= id_value_next;
            timestamp_value <= timestamp_value_next;
            id_ok           <= id_ok_next;
            ts_ok           <= ts_ok_next;
            timeout_err     <= timeout_err_next;
            done            <= done_next;
            busy            <= busy_next;
            avm_read        <= read_next;
            avm_address     <= address_next;
        end
    end

    always_comb begin
        state_next           = state;
        auto_start_next      = auto_start;
        stall_cnt_next       = stall_cnt;
        id_value_next        = id_value;
        timestamp_value_next = timestamp_value;
        id_ok_next           = id_ok;
        ts_ok_next           = ts_ok;
        timeout_err_next     = timeout_err;

        case (state)
            IDLE, FIN: begin
                if (auto_start || start) begin
                    state_next       = RD_ID;
                    auto_start_next  = 1'b0;
                    stall_cnt_next   = '0;
                    id_ok_next       = 1'b0;
                    ts_ok_next       = 1'b0;
                    timeout_err_next = 1'b0;
                end
            end
            RD_ID: begin
                if (!avm_waitrequest) begin
                    id_value_next  = avm_readdata;
                    id_ok_next     = (avm_readdata == EXPECTED_ID);
                    stall_cnt_next = '0;
                    state_next     = RD_TS;
                end else if (stall_cnt == TIMEOUT_CYCLES - 16'd1) begin
                    timeout_err_next = 1'b1;
                    stall_cnt_next   = '0;
                    state_next       = FIN;
                end else begin
                    stall_cnt_next = stall_cnt + 16'd1;
                end
            end
            RD_TS: begin
                if (!avm_waitrequest) begin
                    timestamp_value_next = avm_readdata;
                    ts_ok_next           = (avm_readdata == EXPECTED_TIMESTAMP);
                    stall_cnt_next       = '0;
                    state_next           = FIN;
                end else if (stall_cnt == TIMEOUT_CYCLES - 16'd1) begin
                    timeout_err_next = 1'b1;
                    stall_cnt_next   = '0;
                    state_next       = FIN;
                end else begin
                    stall_cnt_next = stall_cnt + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Bus and status outputs are registered copies of the next state.
        done_next    = (state_next == FIN);
        busy_next    = (state_next == RD_ID) || (state_next == RD_TS);
        read_next    = busy_next;
        address_next = (state_next == RD_TS);
    end

endmodule
